// File: rtl/button_conditioner.sv
// Multi-channel pushbutton conditioner: 2-flop sync, debounce, level plus press/release strobes.
// Optional auto-repeat strobe enabled by defining BTN_AUTOREPEAT_EN.
module button_conditioner #(
  parameter int NUM_CH          = 5,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_RATE     = 2500000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] raw_in,
  output logic [NUM_CH-1:0] level_out,
  output logic [NUM_CH-1:0] press_out,
  output logic [NUM_CH-1:0] release_out,
  output logic [NUM_CH-1:0] repeat_out,
  output logic              any_level_out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_CH-1:0] sync1_q;
  logic [NUM_CH-1:0] sync_q;
  logic [NUM_CH-1:0] cand_q, cand_d;
  logic [NUM_CH-1:0] level_q, level_d;
  logic [NUM_CH-1:0] press_q, press_d;
  logic [NUM_CH-1:0] release_q, release_d;
  logic              any_q, any_d;
  logic [CW-1:0]     cnt_q [NUM_CH];
  logic [CW-1:0]     cnt_d [NUM_CH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync_q    <= '0;
      cand_q    <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      any_q     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= raw_in;
      sync_q    <= sync1_q;
      cand_q    <= cand_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      any_q     <= any_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // The counter only runs while a candidate differs from the accepted level.
  always_comb begin
    cand_d    = cand_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    cnt_d     = cnt_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sync_q[i] != cand_q[i]) begin
        cand_d[i] = sync_q[i];
        cnt_d[i]  = '0;
      end else if (cand_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i]   = cand_q[i];
          press_d[i]   = cand_q[i];
          release_d[i] = ~cand_q[i];
          cnt_d[i]     = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    any_d = |level_d;
  end

  assign level_out     = level_q;
  assign press_out     = press_q;
  assign release_out   = release_q;
  assign any_level_out = any_q;

`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = $clog2(REP_MAX + 1);
  localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_RATE - 1);

  logic [NUM_CH-1:0] rep_q, rep_d;
  logic [RW-1:0]     rep_cnt_q [NUM_CH];
  logic [RW-1:0]     rep_cnt_d [NUM_CH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rep_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        rep_cnt_q[i] <= '0;
      end
    end else begin
      rep_q <= rep_d;
      for (int i = 0; i < NUM_CH; i++) begin
        rep_cnt_q[i] <= rep_cnt_d[i];
      end
    end
  end

  // Down-counter holds cycles remaining until the next repeat pulse.
  always_comb begin
    rep_d     = '0;
    rep_cnt_d = rep_cnt_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (press_d[i]) begin
        rep_d[i]     = 1'b1;
        rep_cnt_d[i] = REP_FIRST;
      end else if (level_q[i] && level_d[i]) begin
        if (rep_cnt_q[i] == '0) begin
          rep_d[i]     = 1'b1;
          rep_cnt_d[i] = REP_NEXT;
        end else begin
          rep_cnt_d[i] = rep_cnt_q[i] - RW'(1);
        end
      end else begin
        rep_cnt_d[i] = '0;
      end
    end
  end

  assign repeat_out = rep_q;
`else
  assign repeat_out = '0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner (NUM_CH=3, DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_RATE=3); repeat expectations follow BTN_AUTOREPEAT_EN.
module tb_button_conditioner;

  localparam int N = 3;
  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] raw_in;
  logic [N-1:0] level_out;
  logic [N-1:0] press_out;
  logic [N-1:0] release_out;
  logic [N-1:0] repeat_out;
  logic         any_level_out;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  // clock / reset
  always #5 clock = ~clock;

  button_conditioner #(
    .NUM_CH         (N),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_RATE    (3)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .raw_in       (raw_in),
    .level_out    (level_out),
    .press_out    (press_out),
    .release_out  (release_out),
    .repeat_out   (repeat_out),
    .any_level_out(any_level_out)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] rep_at_press(input logic [N-1:0] p);
`ifdef BTN_AUTOREPEAT_EN
    return p;
`else
    return '0 & p;
`endif
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_lvl"}, level_out, 3'b000);
    check({tag, "_prs"}, press_out, 3'b000);
    check({tag, "_rel"}, release_out, 3'b000);
    check({tag, "_rep"}, repeat_out, 3'b000);
    check({tag, "_any"}, {2'b00, any_level_out}, 3'b000);
  endtask

  // Drive new_raw; its first sampling edge is offset 0, level moves at offset 6.
  task automatic run_edge(input string tag, input logic [N-1:0] new_raw,
                          input logic [N-1:0] old_lvl);
    raw_in = new_raw;
    for (int off = 0; off <= 6; off++) begin
      tick();
      if (off < 6) begin
        check({tag, "_hold_lvl"}, level_out, old_lvl);
        check({tag, "_hold_prs"}, press_out, 3'b000);
        check({tag, "_hold_rel"}, release_out, 3'b000);
      end else begin
        check({tag, "_lvl"}, level_out, new_raw);
        check({tag, "_prs"}, press_out, new_raw & ~old_lvl);
        check({tag, "_rel"}, release_out, old_lvl & ~new_raw);
        check({tag, "_any"}, {2'b00, any_level_out}, {2'b00, |new_raw});
        check({tag, "_rep"}, repeat_out, rep_at_press(new_raw & ~old_lvl));
      end
    end
    tick();
    check({tag, "_after_lvl"}, level_out, new_raw);
    check({tag, "_after_prs"}, press_out, 3'b000);
    check({tag, "_after_rel"}, release_out, 3'b000);
  endtask

  initial begin
    logic [N-1:0] e;
    reset  = 1'b1;
    raw_in = 3'b111;

    // 1: button held through reset debounces in after release
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("t1_rst");
    end
    reset = 1'b0;
    run_edge("t1_press", 3'b111, 3'b000);
    run_edge("t1_release", 3'b000, 3'b111);

    // 2: 3-cycle glitch on channel 0 is rejected
    raw_in = 3'b001;
    for (int t = 0; t < 15; t++) begin
      if (t == 3) raw_in = 3'b000;
      tick();
      check("t2_lvl", level_out, 3'b000);
      check("t2_prs", press_out, 3'b000);
      check("t2_rel", release_out, 3'b000);
    end

    // 3: channel 1 press held 20 cycles then released
    run_edge("t3_press", 3'b010, 3'b000);
    for (int t = 0; t < 12; t++) begin
      tick();
      check("t3_held_lvl", level_out, 3'b010);
      check("t3_held_prs", press_out, 3'b000);
    end
    run_edge("t3_release", 3'b000, 3'b010);

    // 4: channels 0 and 2 together
    run_edge("t4_press", 3'b101, 3'b000);
    run_edge("t4_release", 3'b000, 3'b101);

    // 5: auto-repeat on channel 0; offsets relative to the press cycle
`ifdef BTN_AUTOREPEAT_EN
    for (int p = 10; p <= 31; p += 3) exp_q.push_back(W'(p));
`endif
    run_edge("t5_press", 3'b001, 3'b000);
    for (int t = 2; t <= 31; t++) begin
      tick();
      e = 3'b000;
      if (exp_q.size() > 0 && exp_q[0] == W'(t)) begin
        e = 3'b001;
        void'(exp_q.pop_front());
      end
      check("t5_rep", repeat_out, e);
      check("t5_lvl", level_out, 3'b001);
    end
    check("t5_rep_q_empty", exp_q.size() == 0 ? 3'b001 : 3'b000, 3'b001);
    run_edge("t5_release", 3'b000, 3'b001);
    for (int t = 0; t < 15; t++) begin
      tick();
      check("t5_rep_after_rel", repeat_out, 3'b000);
    end

    // 6: reset two cycles before a pending press completes
    raw_in = 3'b100;
    for (int off = 0; off <= 4; off++) begin
      tick();
      check("t6_pre_lvl", level_out, 3'b000);
      check("t6_pre_prs", press_out, 3'b000);
    end
    reset = 1'b1;
    #1;
    check_idle("t6_rst_async");
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("t6_rst");
    end
    reset = 1'b0;
    run_edge("t6_resume", 3'b100, 3'b000);
    run_edge("t6_release", 3'b000, 3'b100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
